// File: rtl/blake2_round_sched.sv
// blake2_round_sched
// Issue sequencer for one pipelined BLAKE2 G unit over a full compression.
// Each round issues four column calls (G0..G3), waits G_LAT bubble cycles,
// issues four diagonal calls (G4..G7), then waits G_LAT bubble cycles again.
// Every issue carries the v indices a/b/c/d, the SIGMA message selects x/y
// and a g_idx tag. The same call is replayed G_LAT cycles later as a
// writeback strobe carrying the destination v indices.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start_i              begin a compression (honoured only while idle)
//   busy_o               high from the first issue through the last drain cycle
//   done_o               one-cycle pulse after the final writeback
//   round_o              round of the call being issued
//   issue_v_o            G inputs valid this cycle
//   g_idx_o              G call index 0..7
//   a/b/c/d_sel_o        v indices read for the G inputs
//   x/y_sel_o            message word indices taken from SIGMA
//   wb_v_o               G outputs valid this cycle
//   wb_a/b/c/d_sel_o     v indices written with the G outputs
module blake2_round_sched #(
    parameter int unsigned ROUNDS = 10,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned G_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       round_o,
    output logic             issue_v_o,
    output logic [IDX_W-1:0] g_idx_o,
    output logic [3:0]       a_sel_o,
    output logic [3:0]       b_sel_o,
    output logic [3:0]       c_sel_o,
    output logic [3:0]       d_sel_o,
    output logic [3:0]       x_sel_o,
    output logic [3:0]       y_sel_o,
    output logic             wb_v_o,
    output logic [3:0]       wb_a_sel_o,
    output logic [3:0]       wb_b_sel_o,
    output logic [3:0]       wb_c_sel_o,
    output logic [3:0]       wb_d_sel_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCol,
        StDrainC,
        StDiag,
        StDrainD,
        StDone
    } state_e;

    // Row r holds SIGMA[r][0..15], element 0 in the most significant nibble.
    localparam logic [0:9][0:15][3:0] SIGMA = {
        64'h0123_4567_89ab_cdef,
        64'hea48_9fd6_1c02_b753,
        64'hb8c0_52fd_ae36_7194,
        64'h7931_dcbe_265a_40f8,
        64'h9057_24af_e1bc_683d,
        64'h2c6a_0b83_4d75_fe19,
        64'hc51f_ed4a_0763_928b,
        64'hdb7e_c139_50f4_862a,
        64'h6fe9_b308_c2d7_14a5,
        64'ha284_7615_fb9e_3cd0
    };

    // {a, b, c, d} for each G call: columns first, then diagonals.
    function automatic logic [15:0] idx_map(input logic [2:0] g);
        logic [15:0] m;
        unique case (g)
            3'd0:    m = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    m = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    m = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    m = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    m = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    m = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    m = {4'd2, 4'd7, 4'd8,  4'd13};
            default: m = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
        return m;
    endfunction

    state_e     r_state, w_state_d;
    logic [2:0] r_g, w_g_d;
    logic [3:0] r_round, w_round_d;
    logic [1:0] r_cnt, w_cnt_d;

    logic [G_LAT-1:0] r_dly_v;
    logic [2:0]       r_dly_g [G_LAT];

    logic        w_issue;
    logic        w_drain_end;
    logic [3:0]  w_row;
    logic [15:0] w_rd_idx;
    logic [15:0] w_wb_idx;

    assign w_issue     = (r_state == StCol) || (r_state == StDiag);
    assign w_drain_end = (r_cnt == 2'(G_LAT - 1));
    // round never exceeds 15, so one conditional subtract gives round mod 10
    assign w_row       = (r_round >= 4'd10) ? (r_round - 4'd10) : r_round;
    assign w_rd_idx    = idx_map(r_g);
    assign w_wb_idx    = idx_map(r_dly_g[G_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_g     <= '0;
            r_round <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_g     <= w_g_d;
            r_round <= w_round_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_g_d     = r_g;
        w_round_d = r_round;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_d = StCol;
                    w_g_d     = '0;
                    w_round_d = '0;
                end
            end
            StCol: begin
                // g runs on into 4 so the diagonal phase starts ready
                w_g_d   = r_g + 3'd1;
                w_cnt_d = '0;
                if (r_g == 3'd3) w_state_d = StDrainC;
            end
            StDrainC: begin
                if (w_drain_end) w_state_d = StDiag;
                else             w_cnt_d   = r_cnt + 2'd1;
            end
            StDiag: begin
                // 7 wraps to 0 for the next column phase
                w_g_d   = r_g + 3'd1;
                w_cnt_d = '0;
                if (r_g == 3'd7) w_state_d = StDrainD;
            end
            StDrainD: begin
                if (w_drain_end) begin
                    if (r_round == 4'(ROUNDS - 1)) begin
                        w_state_d = StDone;
                        w_round_d = '0;
                    end else begin
                        w_state_d = StCol;
                        w_round_d = r_round + 4'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 2'd1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Writeback delay line: one stage per cycle of G latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_v <= '0;
            for (int i = 0; i < int'(G_LAT); i++) r_dly_g[i] <= '0;
        end else begin
            r_dly_v[0] <= w_issue;
            r_dly_g[0] <= r_g;
            for (int i = 1; i < int'(G_LAT); i++) begin
                r_dly_v[i] <= r_dly_v[i-1];
                r_dly_g[i] <= r_dly_g[i-1];
            end
        end
    end

    assign busy_o    = (r_state == StCol) || (r_state == StDrainC) ||
                       (r_state == StDiag) || (r_state == StDrainD);
    assign done_o    = (r_state == StDone);
    assign issue_v_o = w_issue;
    assign round_o   = w_issue ? r_round : '0;
    assign g_idx_o   = w_issue ? IDX_W'(r_g) : '0;
    assign a_sel_o   = w_issue ? w_rd_idx[15:12] : '0;
    assign b_sel_o   = w_issue ? w_rd_idx[11:8]  : '0;
    assign c_sel_o   = w_issue ? w_rd_idx[7:4]   : '0;
    assign d_sel_o   = w_issue ? w_rd_idx[3:0]   : '0;
    assign x_sel_o   = w_issue ? SIGMA[w_row][{r_g, 1'b0}] : '0;
    assign y_sel_o   = w_issue ? SIGMA[w_row][{r_g, 1'b1}] : '0;

    assign wb_v_o     = r_dly_v[G_LAT-1];
    assign wb_a_sel_o = wb_v_o ? w_wb_idx[15:12] : '0;
    assign wb_b_sel_o = wb_v_o ? w_wb_idx[11:8]  : '0;
    assign wb_c_sel_o = wb_v_o ? w_wb_idx[7:4]   : '0;
    assign wb_d_sel_o = wb_v_o ? w_wb_idx[3:0]   : '0;

endmodule

// File: tb/tb_blake2_round_sched.sv
// Bench for blake2_round_sched: three instances (defaults, ROUNDS=12,
// G_LAT=2) run in lockstep and are compared every cycle against a schedule
// model computed from cycle number, round period and the SIGMA table.
module tb_blake2_round_sched;

    localparam int ND = 3;
    localparam int RS [ND] = '{10, 12, 10};
    localparam int LS [ND] = '{1, 1, 2};

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       iv;
        logic [3:0] round;
        logic [2:0] g;
        logic [3:0] sa, sb, sc, sd, sx, sy;
        logic       wv;
        logic [3:0] wa, wb, wc, wd;
    } obs_t;

    int sigma [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic       busy [ND];
    logic       done [ND];
    logic [3:0] round [ND];
    logic       iv [ND];
    logic [2:0] gidx [ND];
    logic [3:0] sa [ND], sb [ND], sc [ND], sd [ND], sx [ND], sy [ND];
    logic       wv [ND];
    logic [3:0] wa [ND], wb [ND], wc [ND], wd [ND];

    int n_pass  = 0;
    int n_total = 0;
    int n_iss  [ND];
    int n_wb   [ND];
    int n_done [ND];
    int n_busy [ND];

    always #5 clk = ~clk;

    blake2_round_sched #(.ROUNDS(10), .IDX_W(3), .G_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy[0]), .done_o(done[0]), .round_o(round[0]),
        .issue_v_o(iv[0]), .g_idx_o(gidx[0]),
        .a_sel_o(sa[0]), .b_sel_o(sb[0]), .c_sel_o(sc[0]), .d_sel_o(sd[0]),
        .x_sel_o(sx[0]), .y_sel_o(sy[0]), .wb_v_o(wv[0]),
        .wb_a_sel_o(wa[0]), .wb_b_sel_o(wb[0]), .wb_c_sel_o(wc[0]), .wb_d_sel_o(wd[0])
    );

    blake2_round_sched #(.ROUNDS(12), .IDX_W(3), .G_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy[1]), .done_o(done[1]), .round_o(round[1]),
        .issue_v_o(iv[1]), .g_idx_o(gidx[1]),
        .a_sel_o(sa[1]), .b_sel_o(sb[1]), .c_sel_o(sc[1]), .d_sel_o(sd[1]),
        .x_sel_o(sx[1]), .y_sel_o(sy[1]), .wb_v_o(wv[1]),
        .wb_a_sel_o(wa[1]), .wb_b_sel_o(wb[1]), .wb_c_sel_o(wc[1]), .wb_d_sel_o(wd[1])
    );

    blake2_round_sched #(.ROUNDS(10), .IDX_W(3), .G_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy[2]), .done_o(done[2]), .round_o(round[2]),
        .issue_v_o(iv[2]), .g_idx_o(gidx[2]),
        .a_sel_o(sa[2]), .b_sel_o(sb[2]), .c_sel_o(sc[2]), .d_sel_o(sd[2]),
        .x_sel_o(sx[2]), .y_sel_o(sy[2]), .wb_v_o(wv[2]),
        .wb_a_sel_o(wa[2]), .wb_b_sel_o(wb[2]), .wb_c_sel_o(wc[2]), .wb_d_sel_o(wd[2])
    );

    // Column call j touches (j, 4+j, 8+j, 12+j); diagonal call j shifts
    // each following row one column further to the right.
    function automatic logic [15:0] abcd(input int g);
        int j;
        if (g < 4) return {4'(g), 4'(4 + g), 4'(8 + g), 4'(12 + g)};
        j = g - 4;
        return {4'(j), 4'(4 + (j + 1) % 4), 4'(8 + (j + 2) % 4), 4'(12 + (j + 3) % 4)};
    endfunction

    // G call issued at position p of a round period, or -1 for a bubble.
    function automatic int slot_g(input int p, input int lat);
        if (p < 4) return p;
        if (p >= 4 + lat && p < 8 + lat) return p - lat;
        return -1;
    endfunction

    // Expected outputs c cycles after the start sample (c=0: idle/reset).
    function automatic obs_t model(input int nr, input int lat, input int c);
        obs_t e;
        int per, t, r, g, tw, gw;
        e   = '0;
        per = 8 + 2 * lat;
        if (c >= 1 && c <= nr * per) begin
            e.busy = 1'b1;
            t = c - 1;
            r = t / per;
            g = slot_g(t % per, lat);
            if (g >= 0) begin
                e.iv    = 1'b1;
                e.g     = 3'(g);
                e.round = 4'(r);
                {e.sa, e.sb, e.sc, e.sd} = abcd(g);
                e.sx = 4'(sigma[r % 10][2 * g]);
                e.sy = 4'(sigma[r % 10][2 * g + 1]);
            end
            tw = t - lat;
            if (tw >= 0) begin
                gw = slot_g(tw % per, lat);
                if (gw >= 0) begin
                    e.wv = 1'b1;
                    {e.wa, e.wb, e.wc, e.wd} = abcd(gw);
                end
            end
        end
        if (c == nr * per + 1) e.done = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input int c);
        obs_t o;
        for (int k = 0; k < ND; k++) begin
            o = '{busy[k], done[k], iv[k], round[k], gidx[k], sa[k], sb[k], sc[k], sd[k],
                  sx[k], sy[k], wv[k], wa[k], wb[k], wc[k], wd[k]};
            chk($sformatf("dut%0d cycle%0d outputs", k, c), 64'(o), 64'(model(RS[k], LS[k], c)));
            if (iv[k] === 1'b1)   n_iss[k]++;
            if (wv[k] === 1'b1)   n_wb[k]++;
            if (done[k] === 1'b1) n_done[k]++;
            if (busy[k] === 1'b1) n_busy[k]++;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < ND; k++) begin
            n_iss[k]  = 0;
            n_wb[k]   = 0;
            n_done[k] = 0;
            n_busy[k] = 0;
        end
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("%s dut%0d issues", tag, k), 64'(n_iss[k]), 64'(8 * RS[k]));
            chk($sformatf("%s dut%0d writebacks", tag, k), 64'(n_wb[k]), 64'(8 * RS[k]));
            chk($sformatf("%s dut%0d done pulses", tag, k), 64'(n_done[k]), 64'd1);
            chk($sformatf("%s dut%0d busy cycles", tag, k), 64'(n_busy[k]),
                64'(RS[k] * (8 + 2 * LS[k])));
        end
    endtask

    // start must already hold the cycle-0 value. mode 0: start low afterwards;
    // mode 1: start held high through cycle 101; mode 2: random start while busy.
    task automatic run(input int mode, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            check_all(c);
            case (mode)
                1:       start = (c < 101);
                2:       start = (c < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
                default: start = 1'b0;
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_all(0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_all(0);
        end

        // Full run with start held high: re-starts are ignored until idle.
        clear_counts();
        start = 1'b1;
        run(1, 125);
        check_counts("held");

        // Full run with random start noise while busy.
        clear_counts();
        start = 1'b1;
        run(2, 125);
        check_counts("noise");

        // Abort at cycle 47 with an asynchronous mid-cycle reset.
        start = 1'b1;
        run(0, 47);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(0);
        @(posedge clk);
        #1;
        check_all(0);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 130; i++) begin
            @(posedge clk);
            #1;
            check_all(0);
        end
        chk("abort dut0 no writeback", 64'(n_wb[0]), 64'd0);
        chk("abort dut0 no done", 64'(n_done[0]), 64'd0);

        // Fresh start after the abort begins again at round 0, g 0.
        clear_counts();
        start = 1'b1;
        run(0, 125);
        check_counts("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
